// File: rtl/output_memory_ctrl.sv
// Result-capture memory: byte-masked writes, 1-cycle registered readback, sequential self-clear.
// Define OUTMEM_DUMP_EN to build the in-order dump stream, which holds its word while dump_ready=0.
module output_memory_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   write_data,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    input  logic                clear_req,
    output logic                busy,
    output logic                oob_err,
    input  logic                dump_start,
    output logic                dump_valid,
    input  logic                dump_ready,
    output logic [DATA_W-1:0]   dump_data,
    output logic [ADDR_W-1:0]   dump_addr,
    output logic                dump_last
);
    localparam int              NB      = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
`ifdef OUTMEM_DUMP_EN
        DUMP  = 2'd2,
`endif
        IDLE  = 2'd1
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic active, wr_in_range, rd_in_range, wr_hit, wr_oob, rd_hit;

    assign active      = (state != CLEAR);
    assign wr_in_range = ({1'b0, addr} < DEPTH_X);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);
    assign wr_hit      = active && enable && wr_in_range;
    assign wr_oob      = active && enable && !wr_in_range;
    assign rd_hit      = active && rd_en;

`ifdef OUTMEM_DUMP_EN
    logic              start_dump, dump_hs;
    logic [ADDR_W-1:0] dump_nxt;
    assign start_dump = (state == IDLE) && !clear_req && dump_start;
    assign dump_hs    = dump_valid && dump_ready;
    assign dump_nxt   = dump_addr + ADDR_W'(1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= CLEAR;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        unique case (state)
            CLEAR: begin
                busy = 1'b1;
                if (clr_ptr == LAST) state_nxt = IDLE;
            end
            IDLE: begin
                if (clear_req) state_nxt = CLEAR;
`ifdef OUTMEM_DUMP_EN
                else if (dump_start) state_nxt = DUMP;
            end
            DUMP: begin
                if (dump_hs && dump_last) state_nxt = IDLE;
`endif
            end
            default: state_nxt = CLEAR;
        endcase
    end

    // The pointer wraps to 0 as the clear finishes, so a later clear_req always starts at entry 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) clr_ptr <= '0;
        else if (state == CLEAR) clr_ptr <= (clr_ptr == LAST) ? '0 : clr_ptr + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (wr_hit) begin
            for (int i = 0; i < NB; i++) begin
                if (byte_en[i]) mem[addr][8*i +: 8] <= write_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            oob_err  <= 1'b0;
        end else begin
            rd_valid <= rd_hit;
            if (rd_hit) rd_data <= rd_in_range ? mem[rd_addr] : '0;
            if (wr_oob || (rd_hit && !rd_in_range)) oob_err <= 1'b1;
        end
    end

`ifdef OUTMEM_DUMP_EN
    // Each word is fetched from the array on the edge it becomes presented; later writes to it stay hidden.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dump_valid <= 1'b0;
            dump_data  <= '0;
            dump_addr  <= '0;
            dump_last  <= 1'b0;
        end else if (start_dump) begin
            dump_valid <= 1'b1;
            dump_addr  <= '0;
            dump_data  <= mem[0];
            dump_last  <= (LAST == '0);
        end else if (dump_hs) begin
            if (dump_last) begin
                dump_valid <= 1'b0;
                dump_last  <= 1'b0;
            end else begin
                dump_addr <= dump_nxt;
                dump_data <= mem[dump_nxt];
                dump_last <= (dump_nxt == LAST);
            end
        end
    end
`else
    logic unused_dump;
    assign unused_dump = dump_start ^ dump_ready;
    assign dump_valid  = 1'b0;
    assign dump_data   = '0;
    assign dump_addr   = '0;
    assign dump_last   = 1'b0;
`endif

endmodule

// File: tb/tb_output_memory_ctrl.sv
// Bench for output_memory_ctrl: a 64-deep instance for the main checks, a 48-deep one for range errors.
module tb_output_memory_ctrl;
    localparam int DW = 32;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          enable, rd_en, clear_req, dump_start, dump_ready;
    logic [AW-1:0] addr, rd_addr;
    logic [DW-1:0] write_data;
    logic [3:0]    byte_en;
    logic [DW-1:0] rd_data, dump_data;
    logic          rd_valid, busy, oob_err, dump_valid, dump_last;
    logic [AW-1:0] dump_addr;

    logic          enable_b, rd_en_b, clear_req_b, dump_start_b, dump_ready_b;
    logic [AW-1:0] addr_b, rd_addr_b;
    logic [DW-1:0] write_data_b;
    logic [3:0]    byte_en_b;
    logic [DW-1:0] rd_data_b, dump_data_b;
    logic          rd_valid_b, busy_b, oob_err_b, dump_valid_b, dump_last_b;
    logic [AW-1:0] dump_addr_b;

    output_memory_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(64)) dut (
        .clk(clk), .rst(rst), .enable(enable), .addr(addr), .write_data(write_data),
        .byte_en(byte_en), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .clear_req(clear_req), .busy(busy), .oob_err(oob_err),
        .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_data(dump_data), .dump_addr(dump_addr), .dump_last(dump_last)
    );

    output_memory_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(48)) dut_b (
        .clk(clk), .rst(rst), .enable(enable_b), .addr(addr_b), .write_data(write_data_b),
        .byte_en(byte_en_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .rd_valid(rd_valid_b), .clear_req(clear_req_b), .busy(busy_b), .oob_err(oob_err_b),
        .dump_start(dump_start_b), .dump_valid(dump_valid_b), .dump_ready(dump_ready_b),
        .dump_data(dump_data_b), .dump_addr(dump_addr_b), .dump_last(dump_last_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] model [64];
    logic [DW-1:0] dexp  [64];

    typedef struct {
        logic          en;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [3:0]    be;
        logic          re;
        logic [AW-1:0] ra;
        logic          ev;
        logic [DW-1:0] ed;
    } vec_t;
    vec_t vt [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                            input logic [3:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic idle_inputs();
        enable = 0; addr = '0; write_data = '0; byte_en = '0; rd_en = 0; rd_addr = '0;
        clear_req = 0; dump_start = 0; dump_ready = 0;
        enable_b = 0; addr_b = '0; write_data_b = '0; byte_en_b = '0; rd_en_b = 0; rd_addr_b = '0;
        clear_req_b = 0; dump_start_b = 0; dump_ready_b = 0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model[i] = '0;
    endtask

    // Counts edges until busy falls on each instance; reads/writes presented meanwhile must be ignored.
    task automatic measure_clear(input string nm, input int exp_a, input int exp_b);
        int ca = -1;
        int cb = -1;
        int rv = 0;
        for (int c = 1; c <= 200 && ca < 0; c++) begin
            tick();
            if (rd_valid) rv++;
            if (!busy && ca < 0) ca = c;
            if (!busy_b && cb < 0) cb = c;
        end
        check({nm, "_cycles_a"}, 64'(ca), 64'(exp_a));
        check({nm, "_cycles_b"}, 64'(cb), 64'(exp_b));
        check({nm, "_rd_ignored"}, 64'(rv), 64'd0);
    endtask

    task automatic read_a(input string nm, input logic [AW-1:0] ra, input logic [DW-1:0] exp);
        rd_en = 1; rd_addr = ra;
        tick();
        rd_en = 0;
        check({nm, "_vld"}, {63'd0, rd_valid}, 64'd1);
        check({nm, "_dat"}, {32'd0, rd_data}, {32'd0, exp});
    endtask

    task automatic read_b(input string nm, input logic [AW-1:0] ra, input logic [DW-1:0] exp);
        rd_en_b = 1; rd_addr_b = ra;
        tick();
        rd_en_b = 0;
        check({nm, "_vld"}, {63'd0, rd_valid_b}, 64'd1);
        check({nm, "_dat"}, {32'd0, rd_data_b}, {32'd0, exp});
    endtask

`ifdef OUTMEM_DUMP_EN
    // Accepts entries start..stop-1 against dexp, checking that stalled words stay put.
    task automatic collect(input string nm, input int start, input int stop, input bit rnd);
        int idx = start;
        int cyc = 0;
        bit stalled = 0;
        logic [DW-1:0] sd;
        logic [AW-1:0] sa;
        logic sl;
        while (idx < stop && cyc < 2000) begin
            cyc++;
            check({nm, "_valid"}, {63'd0, dump_valid}, 64'd1);
            if (!dump_valid) break;
            if (stalled) begin
                check({nm, "_stall_dat"}, {32'd0, dump_data}, {32'd0, sd});
                check({nm, "_stall_addr"}, {58'd0, dump_addr}, {58'd0, sa});
                check({nm, "_stall_last"}, {63'd0, dump_last}, {63'd0, sl});
            end
            dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            sd = dump_data; sa = dump_addr; sl = dump_last;
            if (dump_ready) begin
                check({nm, "_dat"}, {32'd0, dump_data}, {32'd0, dexp[idx]});
                check({nm, "_addr"}, {58'd0, dump_addr}, 64'(idx));
                check({nm, "_last"}, {63'd0, dump_last}, {63'd0, idx == 63});
                idx++;
            end
            stalled = !dump_ready;
            tick();
        end
        dump_ready = 0;
        check({nm, "_count"}, 64'(idx), 64'(stop));
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b1, 6'd5,  32'hAABBCCDD, 4'b1111, 1'b0, 6'd0,  1'b0, 32'h0};
        vt[1] = '{1'b1, 6'd5,  32'h11223344, 4'b0101, 1'b1, 6'd5,  1'b1, 32'hAABBCCDD};
        vt[2] = '{1'b0, 6'd0,  32'h0,        4'b0000, 1'b1, 6'd5,  1'b1, 32'hAA22CC44};
        vt[3] = '{1'b1, 6'd5,  32'hFFFFFFFF, 4'b0000, 1'b1, 6'd5,  1'b1, 32'hAA22CC44};
        vt[4] = '{1'b0, 6'd0,  32'h0,        4'b0000, 1'b1, 6'd5,  1'b1, 32'hAA22CC44};
        vt[5] = '{1'b1, 6'd63, 32'h12345678, 4'b1000, 1'b1, 6'd63, 1'b1, 32'h0};
        vt[6] = '{1'b1, 6'd0,  32'hCAFEF00D, 4'b0011, 1'b1, 6'd63, 1'b1, 32'h12000000};
        vt[7] = '{1'b0, 6'd0,  32'h0,        4'b0000, 1'b1, 6'd0,  1'b1, 32'h0000F00D};
        vt[8] = '{1'b0, 6'd0,  32'h0,        4'b0000, 1'b0, 6'd0,  1'b0, 32'h0};

        idle_inputs();
        rst = 1;
        tick();
        check("rst_busy", {63'd0, busy}, 64'd1);
        check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        check("rst_rd_data", {32'd0, rd_data}, 64'd0);
        check("rst_oob", {63'd0, oob_err}, 64'd0);
        check("rst_dump_valid", {63'd0, dump_valid}, 64'd0);
        check("rst_dump_data", {32'd0, dump_data}, 64'd0);
        check("rst_dump_addr", {58'd0, dump_addr}, 64'd0);
        check("rst_dump_last", {63'd0, dump_last}, 64'd0);
        rst = 0;
        measure_clear("reset_clear", 64, 48);
        model_clear();
        read_a("post_reset_rd0", 6'd0, 32'h0);
        read_a("post_reset_rd63", 6'd63, 32'h0);

        for (int i = 0; i < 9; i++) begin
            enable = vt[i].en; addr = vt[i].a; write_data = vt[i].wd; byte_en = vt[i].be;
            rd_en = vt[i].re; rd_addr = vt[i].ra;
            if (vt[i].en) model[vt[i].a] = merge(model[vt[i].a], vt[i].wd, vt[i].be);
            tick();
            check($sformatf("vec%0d_vld", i), {63'd0, rd_valid}, {63'd0, vt[i].ev});
            if (vt[i].ev) check($sformatf("vec%0d_dat", i), {32'd0, rd_data}, {32'd0, vt[i].ed});
        end
        idle_inputs();

        for (int i = 0; i < 400; i++) begin
            logic [DW-1:0] exp_d;
            enable = 1'($urandom_range(0, 1)); addr = 6'($urandom_range(0, 63));
            write_data = $urandom; byte_en = 4'($urandom_range(0, 15));
            rd_en = 1'($urandom_range(0, 1)); rd_addr = 6'($urandom_range(0, 63));
            exp_d = model[rd_addr];
            if (enable) model[addr] = merge(model[addr], write_data, byte_en);
            tick();
            check("rand_vld", {63'd0, rd_valid}, {63'd0, rd_en});
            if (rd_en) check("rand_dat", {32'd0, rd_data}, {32'd0, exp_d});
        end
        idle_inputs();
        check("rand_no_oob", {63'd0, oob_err}, 64'd0);

        clear_req = 1;
        tick();
        clear_req = 0;
        check("clrreq_busy", {63'd0, busy}, 64'd1);
        enable = 1; addr = 6'd0; write_data = 32'hDEADBEEF; byte_en = 4'hF;
        rd_en = 1; rd_addr = 6'd1;
        measure_clear("clear_req", 64, 1);
        idle_inputs();
        model_clear();
        read_a("clr_rd0", 6'd0, 32'h0);
        read_a("clr_rd5", 6'd5, 32'h0);

        check("oob_b_init", {63'd0, oob_err_b}, 64'd0);
        enable_b = 1; addr_b = 6'd50; write_data_b = 32'h55555555; byte_en_b = 4'hF;
        rd_en_b = 1; rd_addr_b = 6'd60;
        tick();
        check("oob_rd_vld", {63'd0, rd_valid_b}, 64'd1);
        check("oob_rd_dat", {32'd0, rd_data_b}, 64'd0);
        check("oob_flag", {63'd0, oob_err_b}, 64'd1);
        enable_b = 1; addr_b = 6'd47; write_data_b = 32'h47474747;
        rd_en_b = 0;
        tick();
        enable_b = 0;
        read_b("oob_rd2", 6'd2, 32'h0);
        read_b("oob_rd18", 6'd18, 32'h0);
        read_b("oob_rd47", 6'd47, 32'h47474747);
        read_b("oob_rd48", 6'd48, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("oob_sticky", {63'd0, oob_err_b}, 64'd1);
        end

`ifdef OUTMEM_DUMP_EN
        for (int i = 0; i < 64; i++) begin
            enable = 1; addr = 6'(i); write_data = 32'(i + 'h100); byte_en = 4'hF;
            model[i] = 32'(i + 'h100);
            dexp[i] = 32'(i + 'h100);
            tick();
        end
        idle_inputs();
        dump_start = 1;
        tick();
        dump_start = 0;
        check("dump_first_vld", {63'd0, dump_valid}, 64'd1);
        check("dump_first_dat", {32'd0, dump_data}, 64'h100);
        collect("dump_bp", 0, 64, 1);
        check("dump_end_vld", {63'd0, dump_valid}, 64'd0);
        check("dump_end_busy", {63'd0, busy}, 64'd0);

        dexp[10] = 32'hBEEF;
        dump_start = 1;
        tick();
        dump_start = 0;
        collect("dump_wr_pre", 0, 3, 0);
        enable = 1; addr = 6'd3; write_data = 32'hDEAD; byte_en = 4'hF;
        tick();
        addr = 6'd10; write_data = 32'hBEEF;
        tick();
        enable = 0;
        model[3] = 32'hDEAD; model[10] = 32'hBEEF;
        collect("dump_wr", 3, 64, 1);
        read_a("dump_wr_rd3", 6'd3, 32'hDEAD);
`else
        dump_start = 1; dump_ready = 1;
        tick();
        tick();
        idle_inputs();
        check("nodump_vld", {63'd0, dump_valid}, 64'd0);
        check("nodump_dat", {32'd0, dump_data}, 64'd0);
        check("nodump_addr", {58'd0, dump_addr}, 64'd0);
        check("nodump_last", {63'd0, dump_last}, 64'd0);
        check("nodump_busy", {63'd0, busy}, 64'd0);
`endif

        clear_req = 1; dump_start = 1;
        tick();
        idle_inputs();
        check("arb_busy", {63'd0, busy}, 64'd1);
        check("arb_no_dump", {63'd0, dump_valid}, 64'd0);
        measure_clear("arb_clear", 64, 1);
        model_clear();

`ifdef OUTMEM_DUMP_EN
        dump_start = 1;
        tick();
        dump_start = 0; dump_ready = 1;
        tick();
        tick();
        check("mid_dump_vld", {63'd0, dump_valid}, 64'd1);
`endif
        rst = 1;
        #1;
        check("mid_rst_vld", {63'd0, dump_valid}, 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd1);
        check("mid_rst_dump_addr", {58'd0, dump_addr}, 64'd0);
        check("mid_rst_oob_b", {63'd0, oob_err_b}, 64'd0);
        idle_inputs();
        tick();
        rst = 0;
        measure_clear("rst_clear2", 64, 48);
        read_a("final_rd63", 6'd63, 32'h0);
        read_b("final_rd47", 6'd47, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
